mips_mc_ctrl: RTL and testbench
===============================

# mips_mc_ctrl

Multi-cycle control FSM for the MIPS datapath: the initiator that issues operation codes to the combinational ALU and consumes its overflow flag. It decodes the instruction-register fields and sequences fetch, decode, execute, memory and writeback. It drives every datapath enable and mux select, and runs a req/ack handshake to the unified instruction/data memory.

## Interface
- EXC_VEC, 32'h0000_0180: value the PC mux presents when pc_src=3; this block only passes it through as a parameter to the datapath.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- opcode  in  6  IR[31:26], stable from DECODE onward.
- funct  in  6  IR[5:0].
- alu_zero  in  1  ALU result == 0, computed by the datapath.
- alu_ov  in  1  ALU overflow flag for the current func.
- mem_ack  in  1  memory completion; valid only while mem_req=1.
- mem_req  out  1  memory access request.
- mem_we  out  1  write access; meaningful with mem_req.
- iord  out  1  address select: 0=PC, 1=ALUOut.
- ir_we  out  1  load IR.
- pc_we  out  1  load PC.
- pc_src  out  2  PC source: 0=ALU, 1=ALUOut, 2=jump target, 3=EXC_VEC.
- reg_we  out  1  register-file write.
- reg_dst  out  1  destination select: 0=rt, 1=rd.
- mem_to_reg  out  1  writeback select: 0=ALUOut, 1=MDR.
- alu_src_a  out  1  ALU A source: 0=PC, 1=rs.
- alu_src_b  out  2  ALU B source: 0=rt, 1=const 4, 2=ext imm, 3=ext imm<<2.
- ext_sign  out  1  immediate extension: 1=sign, 0=zero.
- alu_func  out  6  ALU operation code.
- exc  out  1  one-cycle trap pulse.

## Operation
- ALU func codes:
  - ADD 6'h02, SUB 6'h04, AND 6'h08, OR 6'h10, NOR 6'h20.
  - NAND 6'h03, SLTU 6'h05, SLT 6'h09, XOR 6'h11.
- States: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP, TRAP.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, func=ADD. On the cycle mem_ack=1: ir_we=1, pc_we=1, pc_src=0, then go to DECODE. Otherwise hold.
- DECODE: alu_src_a=0, alu_src_b=3, func=ADD (branch target to ALUOut). Next state by opcode:
  - 00 → EXEC_R.
  - 08/09/0A/0B/0C/0D/0E → EXEC_I.
  - 23/2B → ADDR.
  - 04/05 → BRANCH.
  - 02 → JUMP.
  - R-type funct outside {20–27, 2A, 2B} and any other opcode → TRAP.
- EXEC_R: alu_src_a=1, alu_src_b=0, func from funct:
  - 20/21 ADD, 22/23 SUB, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU.
- EXEC_I: alu_src_a=1, alu_src_b=2, func from opcode:
  - 08/09 ADD, 0A SLT, 0B SLTU, 0C AND, 0D OR, 0E XOR.
  - ext_sign=0 for 0C/0D/0E, 1 otherwise.
- Overflow: funct 20/22 and opcode 08 sample alu_ov in EXEC. If 1 → TRAP and no writeback; if 0 → WB. Unsigned variants never trap.
- WB_R: reg_we=1, reg_dst=1. WB_I: reg_we=1, reg_dst=0. Both → FETCH.
- ADDR: alu_src_a=1, alu_src_b=2, ext_sign=1, func=ADD. Next: lw → MEM_RD, sw → MEM_WR.
- MEM_RD: mem_req=1, iord=1, hold until ack, then → WB_MEM. WB_MEM: reg_we=1, reg_dst=0, mem_to_reg=1, then → FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1, hold until ack, then → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, func=SUB, pc_src=1. pc_we=alu_zero for beq, ~alu_zero for bne. → FETCH.
- JUMP: pc_src=2, pc_we=1, then → FETCH.
- TRAP: exc=1, pc_src=3, pc_we=1, then → FETCH.

## Timing
- State register updates on the rising edge of clk. Outputs are Moore-decoded from state plus opcode/funct. The pc_we qualifiers mem_ack and alu_zero are the only same-cycle input dependencies.
- While rst_n=0: state=FETCH and every output forced 0. First mem_req=1 appears in the cycle after rst_n rises.
- Latency with zero-wait memory (ack in the same cycle as req):
  - R-type/I-type: 4 cycles.
  - lw: 5 cycles. sw: 4 cycles.
  - beq/bne/j: 3 cycles.
  - Trap: 3 cycles from FETCH to the exc pulse.
- Handshake:
  - mem_req, mem_we and iord stay stable until the cycle mem_ack=1 is sampled; req drops the following cycle.
  - mem_ack while mem_req=0 is ignored.
  - Unbounded wait allowed.
- Reset mid-access: req drops asynchronously; a later ack is ignored.
- All non-default defaults are 0; alu_func defaults to ADD in states not listed above.

## Configuration
- CTRL_OVF_TRAP_EN defined: overflow traps as described in Operation.
- CTRL_OVF_TRAP_EN undefined: alu_ov ignored; add/sub/addi behave as addu/subu/addiu. Illegal-instruction TRAP is still present.

## Structure
- Package mips_ctrl_pkg holds:
  - state enum;
  - ALU func constants;
  - opcode and funct constants;
  - pc_src and alu_src_b encodings.
- Sub-module mips_func_dec: combinational (opcode, funct) → {alu_func, ext_sign, ovf_chk, legal}, instantiated once.

## Test plan
- add $3,$1,$2 (0x00221820), ack same cycle → states FETCH, DECODE, EXEC_R, WB_R. In EXEC_R alu_func=6'h02; in WB_R reg_we=1, reg_dst=1.
- lw with mem_ack delayed 3 cycles in MEM_RD → mem_req=1, iord=1 held 4 cycles. reg_we=1 with mem_to_reg=1 exactly one cycle later.
- beq with alu_zero=1 → pc_we=1, pc_src=1 in BRANCH. Same instruction with alu_zero=0 → pc_we=0.
- addi with alu_ov=1 → exc=1 and pc_src=3 for one cycle, no reg_we. With CTRL_OVF_TRAP_EN undefined, reg_we=1 instead.
- Opcode 6'h3F → TRAP after DECODE, exc pulses once, then back to FETCH.
- rst_n low during an sw MEM_WR wait → mem_req=0 immediately. After release, FETCH with mem_we=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_ctrl_pkg
//  Purpose  : Shared encodings for the MIPS multi-cycle controller: state
//             codes, ALU operation codes, opcode/funct values and datapath
//             mux encodings.
//  Revision : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

  // Controller state codes
  typedef logic [3:0] state_t;
  localparam state_t ST_FETCH  = 4'd0;
  localparam state_t ST_DECODE = 4'd1;
  localparam state_t ST_EXEC_R = 4'd2;
  localparam state_t ST_EXEC_I = 4'd3;
  localparam state_t ST_ADDR   = 4'd4;
  localparam state_t ST_MEM_RD = 4'd5;
  localparam state_t ST_MEM_WR = 4'd6;
  localparam state_t ST_WB_R   = 4'd7;
  localparam state_t ST_WB_I   = 4'd8;
  localparam state_t ST_WB_MEM = 4'd9;
  localparam state_t ST_BRANCH = 4'd10;
  localparam state_t ST_JUMP   = 4'd11;
  localparam state_t ST_TRAP   = 4'd12;

  // ALU operation codes
  localparam logic [5:0] ALU_ADD  = 6'h02;
  localparam logic [5:0] ALU_SUB  = 6'h04;
  localparam logic [5:0] ALU_AND  = 6'h08;
  localparam logic [5:0] ALU_OR   = 6'h10;
  localparam logic [5:0] ALU_NOR  = 6'h20;
  localparam logic [5:0] ALU_NAND = 6'h03;
  localparam logic [5:0] ALU_SLTU = 6'h05;
  localparam logic [5:0] ALU_SLT  = 6'h09;
  localparam logic [5:0] ALU_XOR  = 6'h11;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // PC mux select
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_EXC    = 2'd3;

  // ALU B operand select
  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mips_func_dec.sv
`default_nettype none
// ============================================================================
//  Module   : mips_func_dec
//  Purpose  : Combinational instruction classifier. Maps (opcode, funct) to
//             the ALU operation, immediate extension mode, whether the
//             operation is a signed add/sub that may trap on overflow, and
//             whether the instruction is implemented at all.
//  Revision : 1.0 - initial release
// ============================================================================
module mips_func_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [5:0] alu_func,
  output logic       ext_sign,
  output logic       ovf_chk,
  output logic       legal
);

  // Decode table; anything not listed is illegal and falls back to ADD
  always_comb begin
    alu_func = ALU_ADD;
    ext_sign = 1'b1;
    ovf_chk  = 1'b0;
    legal    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        legal = 1'b1;
        case (funct)
          FN_ADD:  begin alu_func = ALU_ADD; ovf_chk = 1'b1; end
          FN_ADDU: alu_func = ALU_ADD;
          FN_SUB:  begin alu_func = ALU_SUB; ovf_chk = 1'b1; end
          FN_SUBU: alu_func = ALU_SUB;
          FN_AND:  alu_func = ALU_AND;
          FN_OR:   alu_func = ALU_OR;
          FN_XOR:  alu_func = ALU_XOR;
          FN_NOR:  alu_func = ALU_NOR;
          FN_SLT:  alu_func = ALU_SLT;
          FN_SLTU: alu_func = ALU_SLTU;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI:  begin legal = 1'b1; alu_func = ALU_ADD; ovf_chk = 1'b1; end
      OP_ADDIU: begin legal = 1'b1; alu_func = ALU_ADD; end
      OP_SLTI:  begin legal = 1'b1; alu_func = ALU_SLT; end
      OP_SLTIU: begin legal = 1'b1; alu_func = ALU_SLTU; end
      OP_ANDI:  begin legal = 1'b1; alu_func = ALU_AND; ext_sign = 1'b0; end
      OP_ORI:   begin legal = 1'b1; alu_func = ALU_OR;  ext_sign = 1'b0; end
      OP_XORI:  begin legal = 1'b1; alu_func = ALU_XOR; ext_sign = 1'b0; end
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mips_mc_ctrl
//  Purpose  : Multi-cycle MIPS control FSM. Sequences fetch, decode, execute,
//             memory and writeback, drives all datapath enables/selects and
//             the req/ack handshake to the unified memory.
//  Config   : CTRL_OVF_TRAP_EN - when defined, signed add/sub/addi that
//             overflow trap instead of writing back.
//  Revision : 1.0 - initial release
// ============================================================================
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = 32'h0000_0180
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       alu_ov,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_sign,
  output logic [5:0] alu_func,
  output logic       exc
);

  state_t     state_q, state_d;
  logic [5:0] dec_func;
  logic       dec_ext, dec_ovf_chk, dec_legal;
  logic       ovf_trap;

  // Raw Moore/qualified outputs before the reset gate
  logic       mem_req_c, mem_we_c, iord_c, ir_we_c, pc_we_c;
  logic [1:0] pc_src_c, alu_src_b_c;
  logic       reg_we_c, reg_dst_c, mem_to_reg_c, alu_src_a_c, ext_sign_c, exc_c;
  logic [5:0] alu_func_c;

  // EXC_VEC is consumed by the datapath PC mux, not by this block
  logic [31:0] unused_exc_vec;
  assign unused_exc_vec = EXC_VEC;

  mips_func_dec u_func_dec (
    .opcode   (opcode),
    .funct    (funct),
    .alu_func (dec_func),
    .ext_sign (dec_ext),
    .ovf_chk  (dec_ovf_chk),
    .legal    (dec_legal)
  );

`ifdef CTRL_OVF_TRAP_EN
  assign ovf_trap = dec_ovf_chk & alu_ov;
`else
  // Overflow is ignored: signed forms behave as their unsigned twins
  logic unused_ovf;
  assign unused_ovf = dec_ovf_chk ^ alu_ov;
  assign ovf_trap   = 1'b0;
`endif

  // State register, returns to FETCH on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    iord_c       = 1'b0;
    ir_we_c      = 1'b0;
    pc_we_c      = 1'b0;
    pc_src_c     = PC_SRC_ALU;
    reg_we_c     = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = SRCB_RT;
    ext_sign_c   = 1'b0;
    alu_func_c   = ALU_ADD;
    exc_c        = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req_c   = 1'b1;
        alu_src_b_c = SRCB_FOUR;
        if (mem_ack) begin
          ir_we_c  = 1'b1;
          pc_we_c  = 1'b1;
          pc_src_c = PC_SRC_ALU;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Speculative branch target into ALUOut
        alu_src_b_c = SRCB_IMM_SH2;
        if (!dec_legal) begin
          state_d = ST_TRAP;
        end else begin
          case (opcode)
            OP_RTYPE:      state_d = ST_EXEC_R;
            OP_J:          state_d = ST_JUMP;
            OP_BEQ, OP_BNE: state_d = ST_BRANCH;
            OP_LW, OP_SW:  state_d = ST_ADDR;
            default:       state_d = ST_EXEC_I;
          endcase
        end
      end
      ST_EXEC_R: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_RT;
        alu_func_c  = dec_func;
        state_d     = ovf_trap ? ST_TRAP : ST_WB_R;
      end
      ST_EXEC_I: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        ext_sign_c  = dec_ext;
        alu_func_c  = dec_func;
        state_d     = ovf_trap ? ST_TRAP : ST_WB_I;
      end
      ST_WB_R: begin
        reg_we_c  = 1'b1;
        reg_dst_c = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_WB_I: begin
        reg_we_c = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        ext_sign_c  = 1'b1;
        state_d     = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        if (mem_ack) state_d = ST_WB_MEM;
      end
      ST_MEM_WR: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        iord_c    = 1'b1;
        if (mem_ack) state_d = ST_FETCH;
      end
      ST_WB_MEM: begin
        reg_we_c     = 1'b1;
        mem_to_reg_c = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_RT;
        alu_func_c  = ALU_SUB;
        pc_src_c    = PC_SRC_ALUOUT;
        pc_we_c     = (opcode == OP_BEQ) ? alu_zero : ~alu_zero;
        state_d     = ST_FETCH;
      end
      ST_JUMP: begin
        pc_src_c = PC_SRC_JUMP;
        pc_we_c  = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_TRAP: begin
        exc_c    = 1'b1;
        pc_src_c = PC_SRC_EXC;
        pc_we_c  = 1'b1;
        state_d  = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Outputs are forced low for as long as reset is held, so an in-flight
  // memory request drops without waiting for a clock edge
  assign mem_req    = rst_n & mem_req_c;
  assign mem_we     = rst_n & mem_we_c;
  assign iord       = rst_n & iord_c;
  assign ir_we      = rst_n & ir_we_c;
  assign pc_we      = rst_n & pc_we_c;
  assign pc_src     = pc_src_c & {2{rst_n}};
  assign reg_we     = rst_n & reg_we_c;
  assign reg_dst    = rst_n & reg_dst_c;
  assign mem_to_reg = rst_n & mem_to_reg_c;
  assign alu_src_a  = rst_n & alu_src_a_c;
  assign alu_src_b  = alu_src_b_c & {2{rst_n}};
  assign ext_sign   = rst_n & ext_sign_c;
  assign alu_func   = alu_func_c & {6{rst_n}};
  assign exc        = rst_n & exc_c;

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_mc_ctrl
//  Purpose  : Self-checking bench for mips_mc_ctrl: directed vector table,
//             hand-written handshake/reset sequences and randomized
//             instruction streams against an instruction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00, funct = 6'h00;
  logic       alu_zero = 1'b0, alu_ov = 1'b0, mem_ack = 1'b0;
  logic       mem_req, mem_we, iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg;
  logic       alu_src_a, ext_sign, exc;
  logic [1:0] pc_src, alu_src_b;
  logic [5:0] alu_func;

  mips_mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .alu_ov(alu_ov), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_sign(ext_sign), .alu_func(alu_func), .exc(exc)
  );

  always #5 clk = ~clk;

  // Packed view of all outputs, MSB first
  logic [20:0] outv;
  assign outv = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
                 mem_to_reg, alu_src_a, alu_src_b, ext_sign, alu_func, exc};

`ifdef CTRL_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int req_iord_cnt = 0;

  typedef struct {
    logic        ack, zero, ov;
    logic [20:0] exp;
  } step_t;
  step_t q[$];

  typedef struct {
    string       name;
    logic [5:0]  op, fn;
    logic        ack, zero, ov;
    logic [20:0] exp;
  } vec_t;
  vec_t tv[$];

  function automatic logic [20:0] mk(input logic req, we, io, irw, pcw,
                                     input logic [1:0] pcs,
                                     input logic rw, rd, m2r, sa,
                                     input logic [1:0] sb,
                                     input logic ext,
                                     input logic [5:0] fn,
                                     input logic ex);
    return {req, we, io, irw, pcw, pcs, rw, rd, m2r, sa, sb, ext, fn, ex};
  endfunction

  // Expected output vectors for each controller step
  logic [20:0] v_fwait, v_fdone, v_dec, v_wbr, v_wbi, v_addr, v_mrd, v_mwr;
  logic [20:0] v_wbm, v_jump, v_trap;

  function automatic logic [20:0] v_exr(input logic [5:0] f);
    return mk(0,0,0,0,0,2'd0,0,0,0,1,2'd0,0,f,0);
  endfunction
  function automatic logic [20:0] v_exi(input logic e, input logic [5:0] f);
    return mk(0,0,0,0,0,2'd0,0,0,0,1,2'd2,e,f,0);
  endfunction
  function automatic logic [20:0] v_br(input logic w);
    return mk(0,0,0,0,w,2'd1,0,0,0,1,2'd0,0,6'h04,0);
  endfunction

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, sample at the falling edge, advance past rising edge
  task automatic cyc(input logic ack, zero, ov, input logic [20:0] exp, input string name);
    mem_ack = ack; alu_zero = zero; alu_ov = ov;
    @(negedge clk);
    if (mem_req && iord) req_iord_cnt++;
    check(name, outv, exp);
    @(posedge clk); #1;
  endtask

  task automatic add_tv(input string n, input logic [5:0] op, fn,
                        input logic ack, zero, ov, input logic [20:0] exp);
    vec_t v;
    v.name = n; v.op = op; v.fn = fn; v.ack = ack; v.zero = zero; v.ov = ov; v.exp = exp;
    tv.push_back(v);
  endtask

  // Spec tables: R-type funct -> {legal, func}, I-type opcode -> {legal, func}
  function automatic logic [6:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h20, 6'h21: return {1'b1, 6'h02};
      6'h22, 6'h23: return {1'b1, 6'h04};
      6'h24: return {1'b1, 6'h08};
      6'h25: return {1'b1, 6'h10};
      6'h26: return {1'b1, 6'h11};
      6'h27: return {1'b1, 6'h20};
      6'h2A: return {1'b1, 6'h09};
      6'h2B: return {1'b1, 6'h05};
      default: return 7'h0;
    endcase
  endfunction
  function automatic logic [6:0] i_alu(input logic [5:0] op);
    case (op)
      6'h08, 6'h09: return {1'b1, 6'h02};
      6'h0A: return {1'b1, 6'h09};
      6'h0B: return {1'b1, 6'h05};
      6'h0C: return {1'b1, 6'h08};
      6'h0D: return {1'b1, 6'h10};
      6'h0E: return {1'b1, 6'h11};
      default: return 7'h0;
    endcase
  endfunction

  task automatic push(input logic ack, zero, ov, input logic [20:0] exp);
    step_t s;
    s.ack = ack; s.zero = zero; s.ov = ov; s.exp = exp;
    q.push_back(s);
  endtask

  // Instruction-level model: expands one instruction into its per-cycle
  // expected outputs given fetch/memory wait counts and ALU flags
  task automatic gen(input logic [5:0] op, fn, input int fw, mw, input logic zero, ov);
    logic [6:0] r, i;
    logic rnd;
    r = r_alu(fn);
    i = i_alu(op);
    for (int k = 0; k < fw; k++) push(1'b0, zero, ov, v_fwait);
    push(1'b1, zero, ov, v_fdone);
    rnd = 1'($urandom);
    push(rnd, zero, ov, v_dec);
    rnd = 1'($urandom);
    if (op == 6'h00 && r[6]) begin
      push(rnd, zero, ov, v_exr(r[5:0]));
      if (TRAP_EN && ov && (fn == 6'h20 || fn == 6'h22)) push(1'b0, zero, ov, v_trap);
      else push(1'b0, zero, ov, v_wbr);
    end else if (op != 6'h00 && i[6]) begin
      push(rnd, zero, ov, v_exi(!(op inside {6'h0C, 6'h0D, 6'h0E}), i[5:0]));
      if (TRAP_EN && ov && op == 6'h08) push(1'b0, zero, ov, v_trap);
      else push(1'b0, zero, ov, v_wbi);
    end else if (op == 6'h23 || op == 6'h2B) begin
      push(rnd, zero, ov, v_addr);
      for (int k = 0; k < mw; k++) push(1'b0, zero, ov, (op == 6'h23) ? v_mrd : v_mwr);
      push(1'b1, zero, ov, (op == 6'h23) ? v_mrd : v_mwr);
      if (op == 6'h23) push(1'($urandom), zero, ov, v_wbm);
    end else if (op == 6'h04 || op == 6'h05) begin
      push(rnd, zero, ov, v_br((op == 6'h04) ? zero : !zero));
    end else if (op == 6'h02) begin
      push(rnd, zero, ov, v_jump);
    end else begin
      push(rnd, zero, ov, v_trap);
    end
  endtask

  task automatic run_q(input string name);
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      cyc(s.ack, s.zero, s.ov, s.exp, name);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op_pool [16];
    logic [5:0] fn_pool [12];
    logic [5:0] op, fn;

    v_fwait = mk(1,0,0,0,0,2'd0,0,0,0,0,2'd1,0,6'h02,0);
    v_fdone = mk(1,0,0,1,1,2'd0,0,0,0,0,2'd1,0,6'h02,0);
    v_dec   = mk(0,0,0,0,0,2'd0,0,0,0,0,2'd3,0,6'h02,0);
    v_wbr   = mk(0,0,0,0,0,2'd0,1,1,0,0,2'd0,0,6'h02,0);
    v_wbi   = mk(0,0,0,0,0,2'd0,1,0,0,0,2'd0,0,6'h02,0);
    v_addr  = mk(0,0,0,0,0,2'd0,0,0,0,1,2'd2,1,6'h02,0);
    v_mrd   = mk(1,0,1,0,0,2'd0,0,0,0,0,2'd0,0,6'h02,0);
    v_mwr   = mk(1,1,1,0,0,2'd0,0,0,0,0,2'd0,0,6'h02,0);
    v_wbm   = mk(0,0,0,0,0,2'd0,1,0,1,0,2'd0,0,6'h02,0);
    v_jump  = mk(0,0,0,0,1,2'd2,0,0,0,0,2'd0,0,6'h02,0);
    v_trap  = mk(0,0,0,0,1,2'd3,0,0,0,0,2'd0,0,6'h02,1);

    // Directed vector table
    add_tv("add_fetch", 6'h00, 6'h20, 1, 0, 0, v_fdone);
    add_tv("add_dec",   6'h00, 6'h20, 0, 0, 0, v_dec);
    add_tv("add_exec",  6'h00, 6'h20, 0, 0, 0, v_exr(6'h02));
    add_tv("add_wb",    6'h00, 6'h20, 0, 0, 0, v_wbr);
    add_tv("beq1_fetch", 6'h04, 6'h00, 1, 1, 0, v_fdone);
    add_tv("beq1_dec",   6'h04, 6'h00, 0, 1, 0, v_dec);
    add_tv("beq1_br",    6'h04, 6'h00, 0, 1, 0, v_br(1'b1));
    add_tv("beq0_fetch", 6'h04, 6'h00, 1, 0, 0, v_fdone);
    add_tv("beq0_dec",   6'h04, 6'h00, 0, 0, 0, v_dec);
    add_tv("beq0_br",    6'h04, 6'h00, 1, 0, 0, v_br(1'b0));
    add_tv("j_fetch", 6'h02, 6'h00, 1, 0, 0, v_fdone);
    add_tv("j_dec",   6'h02, 6'h00, 0, 0, 0, v_dec);
    add_tv("j_jump",  6'h02, 6'h00, 0, 0, 0, v_jump);
    add_tv("ori_fetch", 6'h0D, 6'h00, 1, 0, 0, v_fdone);
    add_tv("ori_dec",   6'h0D, 6'h00, 0, 0, 0, v_dec);
    add_tv("ori_exec",  6'h0D, 6'h00, 0, 0, 0, v_exi(1'b0, 6'h10));
    add_tv("ori_wb",    6'h0D, 6'h00, 0, 0, 0, v_wbi);
    add_tv("addi_fetch", 6'h08, 6'h00, 1, 0, 1, v_fdone);
    add_tv("addi_dec",   6'h08, 6'h00, 0, 0, 1, v_dec);
    add_tv("addi_exec",  6'h08, 6'h00, 0, 0, 1, v_exi(1'b1, 6'h02));
`ifdef CTRL_OVF_TRAP_EN
    add_tv("addi_ovf_trap", 6'h08, 6'h00, 0, 0, 1, v_trap);
`else
    add_tv("addi_ovf_wb",   6'h08, 6'h00, 0, 0, 1, v_wbi);
`endif
    add_tv("ill_fetch", 6'h3F, 6'h00, 1, 0, 0, v_fdone);
    add_tv("ill_dec",   6'h3F, 6'h00, 0, 0, 0, v_dec);
    add_tv("ill_trap",  6'h3F, 6'h00, 0, 0, 0, v_trap);
    add_tv("ill_back",  6'h3F, 6'h00, 0, 0, 0, v_fwait);
    add_tv("ill_fetch2", 6'h3F, 6'h00, 1, 0, 0, v_fdone);
    add_tv("ill_dec2",   6'h3F, 6'h00, 0, 0, 0, v_dec);
    add_tv("ill_trap2",  6'h3F, 6'h00, 0, 0, 0, v_trap);
    add_tv("rfn_fetch", 6'h00, 6'h28, 1, 0, 0, v_fdone);
    add_tv("rfn_dec",   6'h00, 6'h28, 0, 0, 0, v_dec);
    add_tv("rfn_trap",  6'h00, 6'h28, 0, 0, 0, v_trap);

    // Reset: everything low, acks ignored
    mem_ack = 1'b1;
    #12;
    check("reset_outputs", outv, 21'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tv[k]) begin
      opcode = tv[k].op;
      funct  = tv[k].fn;
      cyc(tv[k].ack, tv[k].zero, tv[k].ov, tv[k].exp, tv[k].name);
    end

    // lw with three wait cycles in MEM_RD
    opcode = 6'h23; funct = 6'h00;
    gen(6'h23, 6'h00, 0, 0, 1'b0, 1'b0);
    run_q("lw_nowait");
    gen(6'h23, 6'h00, 0, 3, 1'b0, 1'b0);
    req_iord_cnt = 0;
    run_q("lw_wait3");
    checks++;
    if (req_iord_cnt != 4) begin
      errors++;
      $display("FAIL lw_req_iord_cycles: got %0d expected 4", req_iord_cnt);
    end

    // Reset while sw waits for ack
    opcode = 6'h2B; funct = 6'h00;
    cyc(1'b1, 0, 0, v_fdone, "sw_fetch");
    cyc(1'b0, 0, 0, v_dec,   "sw_dec");
    cyc(1'b0, 0, 0, v_addr,  "sw_addr");
    cyc(1'b0, 0, 0, v_mwr,   "sw_wait0");
    mem_ack = 1'b0;
    @(negedge clk);
    check("sw_wait1", outv, v_mwr);
    #1 rst_n = 1'b0;
    #1 check("sw_rst_async", outv, 21'h0);
    mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("sw_rst_hold", outv, 21'h0);
    rst_n = 1'b1;
    cyc(1'b0, 0, 0, v_fwait, "sw_after_rst");

    // Randomized instruction stream
    op_pool = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
    fn_pool = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h29};
    for (int n = 0; n < 200; n++) begin
      op = op_pool[$urandom_range(0, 15)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 11)];
      opcode = op; funct = fn;
      gen(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom));
      run_q("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
